// File: rtl/tdm_demux_4ch_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer: slot indices,
// frame size and FSM state encoding.
package tdm_demux_4ch_pkg;

    localparam int unsigned NUM_SLOTS = 4;

    localparam logic [1:0] SLOT_A = 2'b00;
    localparam logic [1:0] SLOT_B = 2'b01;
    localparam logic [1:0] SLOT_C = 2'b10;
    localparam logic [1:0] SLOT_D = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SYNC = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux_4ch_slot_ctr.sv
// 2-bit slot counter with synchronous clear, load-to-1 and wrapping increment.
// Priority: rst, clr, load1, inc.
module tdm_slot_ctr
    import tdm_demux_4ch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load1,
    input  logic       inc,
    output logic [1:0] slot
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            slot <= SLOT_A;
        end else if (load1) begin
            slot <= SLOT_B;
        end else if (inc) begin
            slot <= slot + 2'd1;
        end
    end

endmodule

// File: rtl/tdm_demux_4ch.sv
// Receive side of a 4-slot TDM link: aligns on frame_start, gathers slots
// 0..2 in shadow registers and publishes a full frame on the slot-3 beat.
module tdm_demux_4ch
    import tdm_demux_4ch_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             out_valid,
    output logic             frame_err,
    output logic             locked,
    output logic             s1,
    output logic             s0
);

    state_t           state;
    state_t           state_nx;
    logic [1:0]       slot;
    logic             slot_clr;
    logic             slot_load1;
    logic             slot_inc;
    logic [2:0]       shadow_we;
    logic             out_load;
    logic             out_valid_nx;
    logic             frame_err_nx;
    logic [WIDTH-1:0] shadow [0:2];

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (slot_clr),
        .load1 (slot_load1),
        .inc   (slot_inc),
        .slot  (slot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        slot_clr     = 1'b0;
        slot_load1   = 1'b0;
        slot_inc     = 1'b0;
        shadow_we    = '0;
        out_load     = 1'b0;
        out_valid_nx = 1'b0;
        frame_err_nx = 1'b0;

        if (din_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        shadow_we[0] = 1'b1;
                        slot_load1   = 1'b1;
                        state_nx     = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (slot == SLOT_A) begin
                        if (frame_start) begin
                            shadow_we[0] = 1'b1;
                            slot_load1   = 1'b1;
                        end else begin
                            frame_err_nx = 1'b1;
                            slot_clr     = 1'b1;
                            state_nx     = ST_IDLE;
                        end
                    end else if (frame_start) begin
                        // Early marker: drop the partial frame and resync on this beat.
                        frame_err_nx = 1'b1;
                        shadow_we[0] = 1'b1;
                        slot_load1   = 1'b1;
                    end else if (slot == SLOT_D) begin
                        out_load     = 1'b1;
                        out_valid_nx = 1'b1;
                        slot_inc     = 1'b1;
                    end else begin
                        shadow_we[slot] = 1'b1;
                        slot_inc        = 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    slot_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) begin
                if (shadow_we[i]) begin
                    shadow[i] <= din;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= out_valid_nx;
            frame_err <= frame_err_nx;
            if (out_load) begin
                a <= shadow[0];
                b <= shadow[1];
                c <= shadow[2];
                d <= din;
            end
        end
    end

    assign locked = (state == ST_SYNC);
    assign s1     = slot[1];
    assign s0     = slot[0];

endmodule
